// File: rtl/dram_cmd_sched.sv
// dram_cmd_sched: pops one {op, addr} request at a time from the controller
// queue, maps the byte address onto DDR4 row/bank/bank-group/column, and
// issues ACT/RD/WR/PRE with tRCD/tRP/tRAS spacing under an open-page policy.
// Optional: define CLOSE_PAGE_EN to auto-precharge after every access.
module dram_cmd_sched #(
    parameter int unsigned T_RCD   = 24,
    parameter int unsigned T_RP    = 24,
    parameter int unsigned T_RAS   = 52,
    parameter int unsigned T_CL    = 24,
    parameter int unsigned T_CWL   = 20,
    parameter int unsigned T_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [32:0] req_addr,
    output logic        cmd_valid,
    output logic [1:0]  cmd_op,
    output logic [1:0]  cmd_bg,
    output logic [1:0]  cmd_ba,
    output logic [14:0] cmd_row,
    output logic [10:0] cmd_col,
    output logic        done,
    output logic        busy
);

    if (T_RCD < 1 || T_RCD > 127 || T_RP < 1 || T_RP > 127 ||
        T_RAS < 1 || T_RAS > 127 ||
        T_CL + T_BURST < 1 || T_CL + T_BURST > 127 ||
        T_CWL + T_BURST < 1 || T_CWL + T_BURST > 127) begin : g_bad_timing
        $error("dram_cmd_sched: timing parameters must fit the 7-bit counters (1..127)");
    end

    localparam logic [6:0] RCD_LD  = 7'(T_RCD - 1);
    localparam logic [6:0] RP_LD   = 7'(T_RP - 1);
    localparam logic [6:0] TRAS_LD = 7'(T_RAS - 1);
    localparam logic [6:0] RD_LD   = 7'(T_CL + T_BURST - 1);
    localparam logic [6:0] WR_LD   = 7'(T_CWL + T_BURST - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DECIDE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_DATA
    } state_t;

    typedef enum logic [1:0] {
        CMD_ACT = 2'd0, CMD_RD = 2'd1, CMD_WR = 2'd2, CMD_PRE = 2'd3
    } cmd_t;

    state_t      state, state_nx, eff;
    logic        is_wr_q;
    logic [14:0] row_q;
    logic [10:0] col_q;
    logic [1:0]  bg_q, ba_q;
    logic [3:0]  bank;
    logic [6:0]  cnt_q;
    logic [6:0]  rp_cnt_q;
    logic [3:0]  rp_bank_q;
    logic [15:0] open_q;
    logic [6:0]  tras_q [16];
    logic        do_act, do_pre, do_cas;
    cmd_t        cmd_op_c;
    logic        addr_unused;
`ifdef CLOSE_PAGE_EN
    logic [2:0]  rtp_q;
    logic        pre_done_q;
`else
    logic [14:0] open_row_q [16];
`endif

    assign addr_unused = ^req_addr[2:0];
    assign bank        = {bg_q, ba_q};

    // Next state and command decode; DECIDE and expired waits fall straight
    // through into the action state so a ready command goes out this cycle.
    always_comb begin
        state_nx = state;
        eff      = state;
        do_act   = 1'b0;
        do_pre   = 1'b0;
        do_cas   = 1'b0;
        done     = 1'b0;
        case (state)
`ifdef CLOSE_PAGE_EN
            // Every access ended with its own PRE, so the flag is clear here.
            S_DECIDE:   eff = open_q[bank] ? S_PRE : S_ACT;
`else
            S_DECIDE:   eff = !open_q[bank] ? S_ACT :
                              (open_row_q[bank] == row_q) ? S_CAS : S_PRE;
`endif
            S_WAIT_RP:  if (rp_cnt_q == '0) eff = S_ACT;
            S_WAIT_RCD: if (cnt_q == '0) eff = S_CAS;
            default:    ;
        endcase
        case (eff)
            S_IDLE: if (req_valid) state_nx = S_DECIDE;
            S_PRE: begin
                if (tras_q[bank] == '0) begin
                    do_pre   = 1'b1;
                    state_nx = S_WAIT_RP;
                end else begin
                    state_nx = S_PRE;
                end
            end
            S_ACT: begin
                if (rp_cnt_q == '0 || rp_bank_q != bank) begin
                    do_act   = 1'b1;
                    state_nx = S_WAIT_RCD;
                end else begin
                    state_nx = S_ACT;
                end
            end
            S_CAS: begin
                do_cas   = 1'b1;
                state_nx = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
`ifdef CLOSE_PAGE_EN
                if (!pre_done_q && tras_q[bank] == '0 && rtp_q == '0) do_pre = 1'b1;
                if (cnt_q == '0 && (pre_done_q || do_pre)) begin
                    done     = 1'b1;
                    state_nx = S_IDLE;
                end
`else
                if (cnt_q == '0) begin
                    done     = 1'b1;
                    state_nx = S_IDLE;
                end
`endif
            end
            default: state_nx = state;
        endcase
    end

    // Command opcode for whichever action fired this cycle.
    always_comb begin
        cmd_op_c = CMD_ACT;
        if (do_pre)      cmd_op_c = CMD_PRE;
        else if (do_cas) cmd_op_c = is_wr_q ? CMD_WR : CMD_RD;
    end

    assign cmd_valid = do_act | do_pre | do_cas;
    assign cmd_op    = cmd_op_c;
    assign cmd_bg    = bg_q;
    assign cmd_ba    = ba_q;
    assign cmd_row   = row_q;
    assign cmd_col   = col_q;
    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // State register, request latch, timing counters and open-bank tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            is_wr_q   <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            bg_q      <= '0;
            ba_q      <= '0;
            cnt_q     <= '0;
            rp_cnt_q  <= '0;
            rp_bank_q <= '0;
            open_q    <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                tras_q[i] <= '0;
`ifndef CLOSE_PAGE_EN
                open_row_q[i] <= '0;
`endif
            end
`ifdef CLOSE_PAGE_EN
            rtp_q      <= '0;
            pre_done_q <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (state == S_IDLE && req_valid) begin
                is_wr_q <= (req_op == 2'd1);
                row_q   <= req_addr[32:18];
                col_q   <= {req_addr[17:10], req_addr[5:3]};
                ba_q    <= req_addr[9:8];
                bg_q    <= req_addr[7:6];
            end
            for (int unsigned i = 0; i < 16; i++) begin
                if (do_act && bank == 4'(i)) tras_q[i] <= TRAS_LD;
                else if (tras_q[i] != '0)    tras_q[i] <= tras_q[i] - 7'd1;
            end
            if (do_pre) begin
                rp_cnt_q  <= RP_LD;
                rp_bank_q <= bank;
            end else if (rp_cnt_q != '0) begin
                rp_cnt_q <= rp_cnt_q - 7'd1;
            end
            if (do_act)             cnt_q <= RCD_LD;
            else if (do_cas)        cnt_q <= is_wr_q ? WR_LD : RD_LD;
            else if (cnt_q != '0)   cnt_q <= cnt_q - 7'd1;
            if (do_act) begin
                open_q[bank] <= 1'b1;
`ifndef CLOSE_PAGE_EN
                open_row_q[bank] <= row_q;
`endif
            end else if (do_pre) begin
                open_q[bank] <= 1'b0;
            end
`ifdef CLOSE_PAGE_EN
            if (do_cas)             rtp_q <= 3'd3;
            else if (rtp_q != '0)   rtp_q <= rtp_q - 3'd1;
            if (do_cas)             pre_done_q <= 1'b0;
            else if (do_pre)        pre_done_q <= 1'b1;
`endif
        end
    end

endmodule

// File: doc/dram_cmd_sched.md
Name: dram_cmd_sched

Overview:
- Downstream consumer of the 16-entry memory-controller request queue.
- Pops one {op, addr} entry at a time, decodes the 33-bit address into DDR4 row, bank, bank group and column fields, and issues timed ACT/RD/WR/PRE commands.
- Uses an open-page policy with per-bank open-row tracking.
- Pulses `done` back to the queue when each request's data burst completes, which releases the queue entry.

Parameters:
- T_RCD, 24, ACT to RD/WR minimum, cycles
- T_RP, 24, PRE to ACT minimum, cycles
- T_RAS, 52, ACT to PRE same bank minimum, cycles
- T_CL, 24, RD to end of data, excluding burst
- T_CWL, 20, WR to start of data
- T_BURST, 4, burst length, cycles

Ports:
- clk  in  1  DRAM command clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  queue head valid
- req_ready  out  1  block can accept an entry
- req_op  in  2  0=data read, 1=data write, 2=instr fetch (treated as read), 3=reserved (treated as read)
- req_addr  in  33  byte address
- cmd_valid  out  1  command strobe, one-cycle pulse
- cmd_op  out  2  0=ACT, 1=RD, 2=WR, 3=PRE
- cmd_bg  out  2  bank group
- cmd_ba  out  2  bank
- cmd_row  out  15  row, valid for ACT
- cmd_col  out  11  column, valid for RD/WR
- done  out  1  one-cycle pulse when the current request completes
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: synchronous on the clk edge with rst_n=0.
  - All outputs 0 except req_ready=1.
  - FSM goes to IDLE; all 16 bank-open flags cleared; all timers cleared.
  - A reset taken mid-request abandons the request without a done pulse.
- Address map:
  - row = addr[32:18]
  - col = {addr[17:10], addr[5:3]}
  - ba = addr[9:8]
  - bg = addr[7:6]
  - addr[2:0] ignored
  - bank index = {bg, ba}
- Handshake:
  - An entry is accepted on a cycle where req_valid & req_ready.
  - req_ready=1 only in IDLE; it drops the cycle after acceptance.
  - Only one request is in flight at a time; requests are processed strictly in order.
- FSM states: IDLE, DECIDE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, WAIT_DATA.
  - IDLE: on accept, latch op, row, col, bank, then go to DECIDE.
  - DECIDE (cycle after accept): classify the request.
    - Hit (bank open, same row): go to CAS.
    - Closed bank: go to ACT.
    - Conflict (bank open, other row): go to PRE.
    - Each of PRE, ACT and CAS issues its command in the same cycle if its timing is already met. So on a closed bank, ACT is issued at accept cycle +1.
  - PRE: stall until the bank's tRAS timer expires. Then issue PRE, clear the open flag, load the tRP counter, go to WAIT_RP.
  - WAIT_RP: when T_RP cycles have elapsed since PRE, issue ACT in that cycle.
  - ACT: set the open flag, store the row, load the tRCD counter and the bank tRAS timer, go to WAIT_RCD.
  - WAIT_RCD: when T_RCD cycles have elapsed since ACT, issue RD or WR in that cycle.
  - CAS: issue RD (op≠1) or WR (op=1); load the data counter; go to WAIT_DATA.
  - WAIT_DATA: when the data counter expires, pulse `done` and return to IDLE.
    - Read data counter = T_CL+T_BURST; write data counter = T_CWL+T_BURST.
    - req_ready is high the cycle after `done`.
- Timing rule: a command separated by N cycles means issue cycle(second) - issue cycle(first) >= N, exactly N when no other stall applies.
- Per-bank tRAS timers:
  - 16 saturating down-counters, 7 bits wide, loaded with T_RAS-1 on ACT.
  - All timers decrement every cycle, including while the FSM is in other states.
  - PRE is allowed once the timer reads 0.
- cmd_bg, cmd_ba, cmd_row and cmd_col hold the latched values while busy; they are meaningful only when cmd_valid=1.
- Exactly one command is issued per cycle at most.
- Fixed counter widths: tRCD, tRP and data counters are 7 bits. Parameters larger than 127 are illegal; flag them with an elaboration-time $error.

Optional Feature:
- Macro: CLOSE_PAGE_EN.
- When defined:
  - Every request is treated as a closed-bank access.
  - After CAS, in WAIT_DATA, the block issues PRE to the same bank once both of these hold: the tRAS timer is 0, and 4 cycles have passed since the RD/WR (read-to-precharge spacing).
  - That PRE clears the open flag. `done` is not pulsed until both the PRE is issued and the data counter has expired.
  - Subsequent ACTs to the bank respect T_RP from that PRE.
  - A conflict therefore never occurs.
- When undefined: open-page behaviour as above, and no auto-PRE is issued.

Test Plan:
- Read of addr 0x0_0000_0000 accepted at cycle 0 after reset → ACT bg0 ba0 row0 @1; RD col0 @25; done @53; req_ready=1 @54.
- Page hit: after the above, read 0x0_0000_0408 accepted @54 → no ACT; RD col {8'h01,3'h1}=0x009 @55; done @83.
- Conflict: ACT row0 @1; next request is a read of addr 0x0_0004_0000 (row1 bank0), accepted while the tRAS timer for bank0 is still running → PRE @53 (tRAS-limited); ACT row1 @77; RD @101; done @129.
- Write of addr 0x1_FFFF_FFF8 to a closed bank, accepted @0 → ACT bg3 ba3 row 0x7FFF @1; WR col 0x7FF @25; done @49.
- Different banks: requests to banks 0 and 5 back to back → no PRE issued; bank0 open flag retained; a later row0 hit to bank0 issues only RD.
- Reset mid-request: assert rst_n=0 @10, during WAIT_RCD → next cycle cmd_valid=0, done=0, busy=0, req_ready=1; the next request to the same address issues a fresh ACT. With CLOSE_PAGE_EN, the first scenario yields PRE @53 and done @53.
